// File: rtl/irrigation_pkg.sv
// Shared types and defaults for the irrigation pump arbiter.
package irrigation_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        COOLDOWN = 2'd2
    } state_e;

    localparam int DEFAULT_NUM_ZONES = 4;
    localparam int DEFAULT_MIN_ON    = 5;
    localparam int DEFAULT_MIN_OFF   = 3;
    localparam int DEFAULT_MAX_RUN   = 30;

    // Tick counters must be able to hold MAX_RUN itself.
    function automatic int tick_cnt_width(input int max_run);
        return $clog2(max_run + 1);
    endfunction

endpackage

// File: rtl/irrigation_pump_arbiter_if.sv
// Zone request / pump grant bundle between the zone valve logic and the arbiter.
interface irrigation_pump_arbiter_if
    import irrigation_pkg::*;
#(
    parameter int NUM_ZONES = DEFAULT_NUM_ZONES
) ();

    logic                         tick_1hz;
    logic [NUM_ZONES-1:0]         zone_req;
    logic                         rain;
    logic [NUM_ZONES-1:0]         timeout_clr;
    logic                         pump_on;
    logic [NUM_ZONES-1:0]         zone_grant;
    logic [$clog2(NUM_ZONES)-1:0] grant_id;
    logic                         busy;
    logic [NUM_ZONES-1:0]         timeout_lock;

    modport master (
        output tick_1hz, zone_req, rain, timeout_clr,
        input  pump_on, zone_grant, grant_id, busy, timeout_lock
    );

    modport slave (
        input  tick_1hz, zone_req, rain, timeout_clr,
        output pump_on, zone_grant, grant_id, busy, timeout_lock
    );

endinterface

// File: rtl/zone_rr_picker.sv
// Combinational round-robin search: first eligible zone above ptr, with wrap.
module zone_rr_picker
    import irrigation_pkg::*;
#(
    parameter int NUM_ZONES = DEFAULT_NUM_ZONES,
    parameter int ID_W      = $clog2(NUM_ZONES)
) (
    input  logic [NUM_ZONES-1:0] eligible,
    input  logic [ID_W-1:0]      ptr,
    output logic                 found,
    output logic [ID_W-1:0]      idx
);

    // hit[gi] refers to the zone at distance gi+1 from ptr.
    logic [NUM_ZONES-1:0] hit;
    logic [ID_W-1:0]      cand [NUM_ZONES];

    for (genvar gi = 0; gi < NUM_ZONES; gi++) begin : g_cand
        localparam int OFF = gi + 1;
        assign cand[gi] = (int'(ptr) + OFF >= NUM_ZONES) ? ID_W'(int'(ptr) + OFF - NUM_ZONES)
                                                          : ID_W'(int'(ptr) + OFF);
        assign hit[gi]  = eligible[cand[gi]];
    end

    always_comb begin
        found = |hit;
        idx   = '0;
        for (int k = NUM_ZONES - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = cand[k];
            end
        end
    end

endmodule

// File: rtl/irrigation_pump_arbiter.sv
// Round-robin pump arbiter with min on/off anti-short-cycle, max-run lockout and rain abort.
module irrigation_pump_arbiter
    import irrigation_pkg::*;
#(
    parameter int NUM_ZONES = DEFAULT_NUM_ZONES,
    parameter int MIN_ON    = DEFAULT_MIN_ON,
    parameter int MIN_OFF   = DEFAULT_MIN_OFF,
    parameter int MAX_RUN   = DEFAULT_MAX_RUN
) (
    input logic                      clk,
    input logic                      rst,
    irrigation_pump_arbiter_if.slave bus
);

    localparam int ID_W  = $clog2(NUM_ZONES);
    localparam int CNT_W = tick_cnt_width(MAX_RUN);
    localparam logic [CNT_W-1:0] MIN_ON_C  = CNT_W'(MIN_ON);
    localparam logic [CNT_W-1:0] MIN_OFF_C = CNT_W'(MIN_OFF);
    localparam logic [CNT_W-1:0] MAX_RUN_C = CNT_W'(MAX_RUN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic [CNT_W-1:0]     run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0]     off_cnt_q, off_cnt_d;
    logic [NUM_ZONES-1:0] lock_q, lock_d;
    logic [NUM_ZONES-1:0] lock_set;
    logic [NUM_ZONES-1:0] eligible;
    logic                 pick_found;
    logic [ID_W-1:0]      pick_idx;
    logic [CNT_W-1:0]     run_cnt_inc, off_cnt_inc;
    logic                 max_hit;

    assign eligible = bus.zone_req & ~lock_q;

    zone_rr_picker #(
        .NUM_ZONES (NUM_ZONES),
        .ID_W      (ID_W)
    ) u_picker (
        .eligible (eligible),
        .ptr      (ptr_q),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    // Tick-advanced counts, so a tick landing on a threshold acts at this edge.
    assign run_cnt_inc = (bus.tick_1hz && run_cnt_q != CNT_MAX) ? run_cnt_q + CNT_W'(1) : run_cnt_q;
    assign off_cnt_inc = (bus.tick_1hz && off_cnt_q != CNT_MAX) ? off_cnt_q + CNT_W'(1) : off_cnt_q;
    assign max_hit     = (run_cnt_inc >= MAX_RUN_C);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        run_cnt_d  = run_cnt_q;
        off_cnt_d  = off_cnt_q;
        lock_set   = '0;
        case (state_q)
            IDLE: begin
                if (!bus.rain && pick_found) begin
                    state_d    = RUN;
                    grant_id_d = pick_idx;
                    ptr_d      = pick_idx;
                    run_cnt_d  = '0;
                end
            end
            RUN: begin
                run_cnt_d = run_cnt_inc;
                if (max_hit) begin
                    lock_set[grant_id_q] = 1'b1;
                end
                if (bus.rain || max_hit ||
                    (!bus.zone_req[grant_id_q] && run_cnt_inc >= MIN_ON_C)) begin
                    state_d   = COOLDOWN;
                    off_cnt_d = '0;
                end
            end
            COOLDOWN: begin
                off_cnt_d = off_cnt_inc;
                if (off_cnt_inc >= MIN_OFF_C) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A lock being set wins over a clear pulse for the same zone.
        lock_d = (lock_q & ~bus.timeout_clr) | lock_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= ID_W'(NUM_ZONES - 1);
            grant_id_q <= '0;
            run_cnt_q  <= '0;
            off_cnt_q  <= '0;
            lock_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            run_cnt_q  <= run_cnt_d;
            off_cnt_q  <= off_cnt_d;
            lock_q     <= lock_d;
        end
    end

    assign bus.pump_on      = (state_q == RUN);
    assign bus.busy         = (state_q != IDLE);
    assign bus.grant_id     = grant_id_q;
    assign bus.timeout_lock = lock_q;

    for (genvar gi = 0; gi < NUM_ZONES; gi++) begin : g_grant
        assign bus.zone_grant[gi] = (state_q == RUN) && (grant_id_q == ID_W'(gi));
    end

endmodule
